// File: rtl/ternary_decompress.sv
// Streaming expander for packed ternary activations: each byte of an input word
// carries 5 trits, and one byte's trits are emitted per output handshake.
module ternary_decompress #(
  parameter int DATA_WIDTH = 32,
  parameter int TRITS      = 5,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [IDX_W-1:0]      in_nbytes_m1_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*TRITS-1:0]    out_trits_o,
  output logic                  out_last_o,
  output logic                  out_err_o,
  output logic                  err_sticky_o
);

  localparam int MAX_CODE = (3 ** TRITS) - 1;

  if ((DATA_WIDTH % 8) != 0 || (3 ** TRITS) > 256) begin : g_bad_params
    $error("ternary_decompress: DATA_WIDTH must be a multiple of 8 and 3**TRITS must fit in a byte");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_idx_q, last_idx_d;
  logic                  sticky_q, sticky_d;

  logic                  full_q;
  logic [7:0]            cur_byte;
  logic                  cur_illegal;
  logic                  in_fire;
  logic                  out_fire;

  // Digit k of the base-3 representation is (t_k + 1); map it back to a signed 2-bit code.
  function automatic logic [2*TRITS-1:0] decode_byte(input logic [7:0] b);
    logic [7:0]         v;
    logic [7:0]         d;
    logic [2*TRITS-1:0] t;
    v = b;
    t = '0;
    for (int k = 0; k < TRITS; k++) begin
      d = v % 8'd3;
      v = v / 8'd3;
      case (d)
        8'd0:    t[2*k +: 2] = 2'b11;
        8'd1:    t[2*k +: 2] = 2'b00;
        default: t[2*k +: 2] = 2'b01;
      endcase
    end
    return t;
  endfunction

  assign full_q      = (state_q == FULL);
  assign cur_byte    = word_q[{idx_q, 3'b000} +: 8];
  assign cur_illegal = (int'(cur_byte) > MAX_CODE);

  assign out_valid_o  = full_q;
  assign out_last_o   = full_q & (idx_q == last_idx_q);
  assign out_err_o    = full_q & cur_illegal;
  assign out_trits_o  = (full_q && !cur_illegal) ? decode_byte(cur_byte) : '0;
  assign err_sticky_o = sticky_q;

  // Accepting during the last beat lets the next word start with no bubble.
  assign in_ready_o = !full_q | (out_ready_i & out_last_o);
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = full_q & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      word_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      sticky_q   <= sticky_d;
    end
  end

  // Flush outranks both handshakes; a new word outranks retiring the old one.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    sticky_d   = sticky_q;

    if (clear_i) begin
      state_d  = EMPTY;
      idx_d    = '0;
      sticky_d = 1'b0;
    end else begin
      if (out_fire && out_err_o) begin
        sticky_d = 1'b1;
      end
      if (in_fire) begin
        state_d    = FULL;
        word_d     = in_data_i;
        last_idx_d = in_nbytes_m1_i;
        idx_d      = '0;
      end else if (out_fire) begin
        if (out_last_o) begin
          state_d = EMPTY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ternary_decompress.sv
// Directed bench for ternary_decompress: a vector table of words with
// hand-decoded beats, plus sequences for back-to-back, stall, flush and reset.
module tb_ternary_decompress;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_nbytes_m1;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_trits;
  logic        out_last;
  logic        out_err;
  logic        err_sticky;

  int   checks   = 0;
  int   failures = 0;
  logic sticky_exp;

  typedef struct {
    logic [31:0]      data;
    logic [1:0]       m1;
    logic [3:0][9:0]  trits;
    logic [3:0]       err;
  } vec_t;

  vec_t vecs [5];

  localparam logic [31:0] WORD_A = 32'h00F27979;
  localparam logic [31:0] WORD_B = 32'h77F20079;
  localparam logic [31:0] WORD_C = 32'h00F3F279;

  logic [3:0][9:0] trits_a;
  logic [3:0][9:0] trits_b;
  logic [7:0][9:0] trits_ab;
  logic [3:0][9:0] trits_c;

  ternary_decompress #(.DATA_WIDTH(32), .TRITS(5)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .in_nbytes_m1_i (in_nbytes_m1),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_trits_o    (out_trits),
    .out_last_o     (out_last),
    .out_err_o      (out_err),
    .err_sticky_o   (err_sticky)
  );

  always #5 clk = ~clk;

  task applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] m1,
                     input logic rdy, input logic clr);
    in_valid     = v;
    in_data      = d;
    in_nbytes_m1 = m1;
    out_ready    = rdy;
    clear        = clr;
  endtask

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Presents one word for a single cycle; returns at the negedge where beat 0 is visible.
  task sendWord(input logic [31:0] d, input logic [1:0] m1);
    @(negedge clk);
    applyStimulus(1'b1, d, m1, 1'b1, 1'b0);
    #1;
    checkOutput("accept_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    trits_a  = {10'h3FF, 10'h155, 10'h000, 10'h000};
    trits_b  = {10'h00D, 10'h155, 10'h3FF, 10'h000};
    trits_ab = {trits_b, trits_a};
    trits_c  = {10'h3FF, 10'h000, 10'h155, 10'h000};

    vecs[0] = '{data: WORD_A,        m1: 2'd3, trits: trits_a,                                    err: 4'b0000};
    vecs[1] = '{data: 32'h00000077,  m1: 2'd0, trits: {10'h0, 10'h0, 10'h0, 10'h00D},              err: 4'b0000};
    vecs[2] = '{data: 32'hFF285101,  m1: 2'd2, trits: {10'h0, 10'h300, 10'h0FF, 10'h3FC},          err: 4'b0000};
    vecs[3] = '{data: 32'h000000F3,  m1: 2'd0, trits: {10'h0, 10'h0, 10'h0, 10'h000},              err: 4'b0001};
    vecs[4] = '{data: 32'h0000FF79,  m1: 2'd1, trits: {10'h0, 10'h0, 10'h000, 10'h000},            err: 4'b0010};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_trits", 32'(out_trits), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_err", 32'(out_err), 32'd0);
    checkOutput("rst_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sticky_exp = 1'b0;

    for (int v = 0; v < 5; v++) begin
      sendWord(vecs[v].data, vecs[v].m1);
      for (int b = 0; b <= int'(vecs[v].m1); b++) begin
        #1;
        checkOutput($sformatf("vec%0d_beat%0d_valid", v, b), 32'(out_valid), 32'd1);
        checkOutput($sformatf("vec%0d_beat%0d_trits", v, b), 32'(out_trits), 32'(vecs[v].trits[b]));
        checkOutput($sformatf("vec%0d_beat%0d_last", v, b), 32'(out_last), 32'(b == int'(vecs[v].m1)));
        checkOutput($sformatf("vec%0d_beat%0d_err", v, b), 32'(out_err), 32'(vecs[v].err[b]));
        if (vecs[v].err[b]) sticky_exp = 1'b1;
        @(negedge clk);
      end
      #1;
      checkOutput($sformatf("vec%0d_drained", v), 32'(out_valid), 32'd0);
      checkOutput($sformatf("vec%0d_sticky", v), 32'(err_sticky), 32'(sticky_exp));
    end

    // Two words presented continuously: eight beats with no gap.
    @(negedge clk);
    applyStimulus(1'b1, WORD_A, 2'd3, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, WORD_B, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("b2b_beat%0d_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("b2b_beat%0d_trits", i), 32'(out_trits), 32'(trits_ab[i]));
      checkOutput($sformatf("b2b_beat%0d_last", i), 32'(out_last), 32'(i == 3 || i == 7));
      if (i < 4) checkOutput($sformatf("b2b_beat%0d_in_ready", i), 32'(in_ready), 32'(i == 3));
      @(negedge clk);
    end
    #1;
    checkOutput("b2b_drained", 32'(out_valid), 32'd0);

    // Three-cycle stall on beat 1 of WORD_B.
    sendWord(WORD_B, 2'd3);
    #1;
    checkOutput("bp_beat0_trits", 32'(out_trits), 32'(trits_b[0]));
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput($sformatf("bp_stall%0d_valid", s), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_stall%0d_trits", s), 32'(out_trits), 32'(trits_b[1]));
      checkOutput($sformatf("bp_stall%0d_in_ready", s), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp_stall%0d_last", s), 32'(out_last), 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    for (int b = 1; b < 4; b++) begin
      #1;
      checkOutput($sformatf("bp_beat%0d_trits", b), 32'(out_trits), 32'(trits_b[b]));
      checkOutput($sformatf("bp_beat%0d_last", b), 32'(out_last), 32'(b == 3));
      @(negedge clk);
    end
    #1;
    checkOutput("bp_drained", 32'(out_valid), 32'd0);
    checkOutput("sticky_persists", 32'(err_sticky), 32'(sticky_exp));

    // Flush during beat 1 drops the word and clears the sticky error.
    sendWord(WORD_A, 2'd3);
    #1;
    checkOutput("clr_beat0_trits", 32'(out_trits), 32'(trits_a[0]));
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b1);
    #1;
    checkOutput("clr_beat1_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    #1;
    checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_sticky", 32'(err_sticky), 32'd0);
    checkOutput("clr_in_ready", 32'(in_ready), 32'd1);

    // A word offered in the flush cycle is discarded.
    @(negedge clk);
    applyStimulus(1'b1, WORD_A, 2'd3, 1'b1, 1'b1);
    #1;
    checkOutput("clr_in_fire_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 1'b0);
    #1;
    checkOutput("clr_in_fire_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset in the last beat, after an illegal byte set the sticky flag.
    sendWord(WORD_C, 2'd3);
    for (int b = 0; b < 3; b++) begin
      #1;
      checkOutput($sformatf("rstw_beat%0d_trits", b), 32'(out_trits), 32'(trits_c[b]));
      checkOutput($sformatf("rstw_beat%0d_err", b), 32'(out_err), 32'(b == 2));
      @(negedge clk);
    end
    #1;
    checkOutput("rstw_beat3_valid", 32'(out_valid), 32'd1);
    checkOutput("rstw_beat3_trits", 32'(out_trits), 32'(trits_c[3]));
    checkOutput("rstw_sticky_set", 32'(err_sticky), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_rst_trits", 32'(out_trits), 32'd0);
    checkOutput("async_rst_last", 32'(out_last), 32'd0);
    checkOutput("async_rst_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_rst_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ternary_decompress.md
Name: ternary_decompress

Overview:
- Streaming expander for packed ternary activations: each input word carries packed bytes, and each byte encodes 5 trits.
- Emits one byte's worth of decoded trits (5 × 2-bit signed codes) per output handshake.
- Sits on the load path of the TNN datapath as the inverse of threshold_compress: it feeds unpacked trits to the ternary MAC/dot-product stage from GPR or memory words.
- Valid/ready on both sides; a single-word holding buffer gives full throughput with no bubbles.

Parameters:
- DATA_WIDTH, 32, input word width in bits; must be a multiple of 8. BYTES = DATA_WIDTH/8.
- TRITS, 5, trits per byte; fixed, not overridable in practice (localparam check: 3^TRITS <= 256).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous flush; drops the buffered word and clears the sticky error.
- in_valid_i  input  1  input word valid.
- in_ready_o  output  1  block can accept a word this cycle.
- in_data_i  input  DATA_WIDTH  packed bytes; byte 0 = bits [7:0] is decoded first.
- in_nbytes_m1_i  input  $clog2(BYTES)  number of valid bytes minus 1 (3 → all 4 bytes).
- out_valid_o  output  1  decoded byte available.
- out_ready_i  input  1  consumer accepts the beat.
- out_trits_o  output  2*TRITS  trit k in bits [2k+1:2k]; codes 2'b00=0, 2'b01=+1, 2'b11=-1.
- out_last_o  output  1  beat is the last valid byte of its word.
- out_err_o  output  1  current byte is an illegal code (> 242).
- err_sticky_o  output  1  sticky OR of out_err_o over fired beats.

Behaviour:
- Encoding:
  - byte = Σ_{k=0..4} (t_k+1)·3^k, with t_k ∈ {-1,0,+1}; legal range is 0..242.
  - Decoding uses repeated div/mod by 3, or an equivalent 243-entry constant function/LUT.
  - Bytes 243..255: out_trits_o = all 2'b00 and out_err_o = 1.
- State:
  - word_q[DATA_WIDTH], idx_q (byte index), last_idx_q, full_q.
  - Two states: EMPTY (full_q=0) and FULL (full_q=1).
- Reset (rst_i=1, asynchronous): full_q=0, idx_q=0, last_idx_q=0, word_q=0, err_sticky_o=0.
  - Hence out_valid_o=0, in_ready_o=1, out_trits_o=0, out_last_o=0, out_err_o=0.
- Output decode is combinational from word_q byte idx_q; out_valid_o = full_q.
  - out_last_o = full_q & (idx_q == last_idx_q).
  - out_err_o is gated by full_q.
- in_ready_o = !full_q | (out_ready_i & out_last_o). This combinational path through out_ready_i is intentional and gives zero-bubble back-to-back words.
- Input fire (in_valid_i & in_ready_o):
  - word_q ← in_data_i, last_idx_q ← in_nbytes_m1_i, idx_q ← 0, full_q ← 1.
  - First beat is visible the cycle after acceptance (latency 1).
- Output fire (out_valid_o & out_ready_i):
  - Not last: idx_q ← idx_q+1.
  - Last with no simultaneous input fire: full_q ← 0, idx_q ← 0.
  - Last with a simultaneous input fire: the new word loads and the input fire takes priority.
- Stall: out_valid_o=1 with out_ready_i=0 holds all outputs stable. out_valid_o never drops without a fire.
- Throughput: one beat per cycle when out_ready_i is held high; a word of N bytes occupies N cycles.
- err_sticky_o is set on any output fire with out_err_o=1; it is cleared only by rst_i or clear_i.
- clear_i (synchronous, priority over all fires):
  - full_q ← 0, idx_q ← 0, err_sticky_o ← 0.
  - in_ready_o still evaluates normally that cycle, but any input fire in that cycle is discarded.
  - The in-flight beat is dropped.
- in_nbytes_m1_i is sampled only on input fire. Out-of-range values cannot occur for DATA_WIDTH=32.
- Reset mid-word: the buffer is lost immediately (asynchronous); no beat is emitted after reset.

Test Plan:
- Reset, then in_data_i=32'h00F27979, nbytes_m1=3, out_ready_i=1 → four beats on consecutive cycles starting 1 cycle after accept:
  - out_trits_o = 10'h000, 10'h000, 10'h155, 10'h3FF.
  - out_last_o only on the 4th beat; out_err_o=0 throughout.
- Byte 0x77 alone (in_data_i=32'h00000077, nbytes_m1=0) → a single beat with out_trits_o=10'h00D (t0=+1, t1=-1, rest 0) and out_last_o=1. Next cycle out_valid_o=0 if no new word.
- Back-to-back: two 4-byte words presented continuously with out_ready_i=1 → 8 consecutive beats with no gap. in_ready_o=1 in the cycle of beat 4.
- Backpressure: hold out_ready_i=0 for 3 cycles mid-word → outputs are stable, in_ready_o=0, and the beat sequence is unchanged after release.
- Illegal code: byte 0xF3 → out_trits_o=10'h000 and out_err_o=1. err_sticky_o=1 from the next cycle; it stays set through later legal words and drops only after clear_i.
- Flush/reset: assert clear_i during beat 2 of a word → out_valid_o=0 next cycle and err_sticky_o=0. Assert rst_i asynchronously mid-word → out_valid_o falls immediately and in_ready_o=1.
